fb_write_ctrl: RTL and testbench

Write-port controller for the 3-bit, 214x160 framebuffer SRAM. Shares the single framebuffer write port between two pixel writers, the CPU and the rasterizer, using a registered req/ack handshake and round-robin arbitration. Also contains a clear engine that fills the whole framebuffer with one colour. Sits between the CPU/rasterizer and the framebuffer write port; the VGA output controller keeps exclusive use of the read port.

---
 rtl/fb_write_ctrl.sv | 145 ++++++++++++++
 tb/tb_fb_write_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_ctrl.sv
// Framebuffer write-port controller: round-robin arbitration between the CPU
// and the rasterizer with a registered req/ack handshake, plus a clear engine
// that fills every valid framebuffer address with one colour.
module fb_write_ctrl #(
  parameter int A_WIDTH   = 16,
  parameter int D_WIDTH   = 3,
  parameter int FB_PIXELS = 34240
) (
  input  logic               clk,
  input  logic               n_rst_async,
  input  logic               clear_req,
  input  logic [D_WIDTH-1:0] clear_color,
  output logic               clear_busy,
  input  logic               cpu_req,
  input  logic [A_WIDTH-1:0] cpu_addr,
  input  logic [D_WIDTH-1:0] cpu_pixel,
  output logic               cpu_ack,
  input  logic               rast_req,
  input  logic [A_WIDTH-1:0] rast_addr,
  input  logic [D_WIDTH-1:0] rast_pixel,
  output logic               rast_ack,
  output logic               fb_write_en,
  output logic [A_WIDTH-1:0] fb_write_addr,
  output logic [D_WIDTH-1:0] fb_write_pixel
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;
  typedef enum logic {GR_CPU, GR_RAST} grant_e;

  // Last address the clear engine writes; one bit wider limit for range checks
  // so the comparison cannot wrap.
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(FB_PIXELS - 1);
  localparam logic [A_WIDTH:0]   PIX_LIMIT = (A_WIDTH + 1)'(FB_PIXELS);

  state_e               state_q, state_d;
  grant_e               last_grant_q, last_grant_d;
  logic [A_WIDTH-1:0]   counter_q, counter_d;
  logic [D_WIDTH-1:0]   color_q, color_d;
  logic                 cpu_ack_q, cpu_ack_d;
  logic                 rast_ack_q, rast_ack_d;
  logic                 en_q, en_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [D_WIDTH-1:0]   pixel_q, pixel_d;
  logic                 busy_q, busy_d;

  logic                 cpu_elig, rast_elig;
  logic                 cpu_in_range, rast_in_range;
  logic [A_WIDTH-1:0]   count_inc;

  // A requester whose ack is on the bus right now still shows req high; it
  // must not be granted again until its next request is presented.
  assign cpu_elig      = cpu_req  & ~cpu_ack_q;
  assign rast_elig     = rast_req & ~rast_ack_q;
  assign cpu_in_range  = {1'b0, cpu_addr}  < PIX_LIMIT;
  assign rast_in_range = {1'b0, rast_addr} < PIX_LIMIT;
  assign count_inc     = counter_q + 1'b1;

  // Next-state and registered-output decode for the clear FSM and arbiter.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    counter_d    = counter_q;
    color_d      = color_q;
    cpu_ack_d    = 1'b0;
    rast_ack_d   = 1'b0;
    en_d         = 1'b0;
    addr_d       = addr_q;
    pixel_d      = pixel_q;
    busy_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          // Clear beats pending requests; the first clear write goes out now.
          state_d   = ST_CLEAR;
          color_d   = clear_color;
          counter_d = '0;
          en_d      = 1'b1;
          addr_d    = '0;
          pixel_d   = clear_color;
          busy_d    = 1'b1;
        end else if (cpu_elig && (!rast_elig || last_grant_q == GR_RAST)) begin
          cpu_ack_d    = 1'b1;
          last_grant_d = GR_CPU;
          en_d         = cpu_in_range;
          addr_d       = cpu_addr;
          pixel_d      = cpu_pixel;
        end else if (rast_elig) begin
          rast_ack_d   = 1'b1;
          last_grant_d = GR_RAST;
          en_d         = rast_in_range;
          addr_d       = rast_addr;
          pixel_d      = rast_pixel;
        end
      end
      ST_CLEAR: begin
        counter_d = count_inc;
        en_d      = 1'b1;
        addr_d    = count_inc;
        pixel_d   = color_q;
        busy_d    = 1'b1;
        if (count_inc == LAST_ADDR) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any clear in progress.
  always_ff @(posedge clk or negedge n_rst_async) begin
    if (!n_rst_async) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GR_RAST;
      counter_q    <= '0;
      color_q      <= '0;
      cpu_ack_q    <= 1'b0;
      rast_ack_q   <= 1'b0;
      en_q         <= 1'b0;
      addr_q       <= '0;
      pixel_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      counter_q    <= counter_d;
      color_q      <= color_d;
      cpu_ack_q    <= cpu_ack_d;
      rast_ack_q   <= rast_ack_d;
      en_q         <= en_d;
      addr_q       <= addr_d;
      pixel_q      <= pixel_d;
      busy_q       <= busy_d;
    end
  end

  assign clear_busy     = busy_q;
  assign cpu_ack        = cpu_ack_q;
  assign rast_ack       = rast_ack_q;
  assign fb_write_en    = en_q;
  assign fb_write_addr  = addr_q;
  assign fb_write_pixel = pixel_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed testbench for fb_write_ctrl. Inputs change and outputs are sampled
// on the falling clock edge, half a cycle after the registers update.
module tb_fb_write_ctrl;

  localparam int A_WIDTH   = 16;
  localparam int D_WIDTH   = 3;
  localparam int FB_PIXELS = 34240;

  logic               clk = 1'b0;
  logic               n_rst_async;
  logic               clear_req;
  logic [D_WIDTH-1:0] clear_color;
  logic               clear_busy;
  logic               cpu_req;
  logic [A_WIDTH-1:0] cpu_addr;
  logic [D_WIDTH-1:0] cpu_pixel;
  logic               cpu_ack;
  logic               rast_req;
  logic [A_WIDTH-1:0] rast_addr;
  logic [D_WIDTH-1:0] rast_pixel;
  logic               rast_ack;
  logic               fb_write_en;
  logic [A_WIDTH-1:0] fb_write_addr;
  logic [D_WIDTH-1:0] fb_write_pixel;

  int checks = 0;
  int passes = 0;

  fb_write_ctrl #(
    .A_WIDTH  (A_WIDTH),
    .D_WIDTH  (D_WIDTH),
    .FB_PIXELS(FB_PIXELS)
  ) dut (
    .clk           (clk),
    .n_rst_async   (n_rst_async),
    .clear_req     (clear_req),
    .clear_color   (clear_color),
    .clear_busy    (clear_busy),
    .cpu_req       (cpu_req),
    .cpu_addr      (cpu_addr),
    .cpu_pixel     (cpu_pixel),
    .cpu_ack       (cpu_ack),
    .rast_req      (rast_req),
    .rast_addr     (rast_addr),
    .rast_pixel    (rast_pixel),
    .rast_ack      (rast_ack),
    .fb_write_en   (fb_write_en),
    .fb_write_addr (fb_write_addr),
    .fb_write_pixel(fb_write_pixel)
  );

  always #10 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drop_reqs();
    cpu_req   = 1'b0;
    rast_req  = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic test_reset();
    n_rst_async = 1'b0;
    clear_req   = 1'b0;
    clear_color = 3'd0;
    cpu_req     = 1'b1; cpu_addr  = 16'd10; cpu_pixel  = 3'd1;
    rast_req    = 1'b1; rast_addr = 16'd20; rast_pixel = 3'd6;
    step(3);
    checks++; if ({cpu_ack, rast_ack, fb_write_en, clear_busy} !== 4'b0000)
      $display("FAIL reset_flags: got ack/ack/en/busy=%b want 0000", {cpu_ack, rast_ack, fb_write_en, clear_busy}); else passes++;
    checks++; if (fb_write_addr !== 16'd0 || fb_write_pixel !== 3'd0)
      $display("FAIL reset_bus: got addr=%0d pix=%0d want 0/0", fb_write_addr, fb_write_pixel); else passes++;
    n_rst_async = 1'b1;
    step();
    // last_grant resets to RAST, so the CPU wins the first contention.
    checks++; if (cpu_ack !== 1'b1 || rast_ack !== 1'b0 || fb_write_addr !== 16'd10 || fb_write_pixel !== 3'd1)
      $display("FAIL reset_first_grant: got cack=%b rack=%b addr=%0d pix=%0d want 1 0 10 1", cpu_ack, rast_ack, fb_write_addr, fb_write_pixel); else passes++;
    step();
    checks++; if (rast_ack !== 1'b1 || cpu_ack !== 1'b0 || fb_write_addr !== 16'd20 || fb_write_pixel !== 3'd6)
      $display("FAIL reset_second_grant: got cack=%b rack=%b addr=%0d pix=%0d want 0 1 20 6", cpu_ack, rast_ack, fb_write_addr, fb_write_pixel); else passes++;
    drop_reqs();
    step();
  endtask

  task automatic test_single_cpu();
    cpu_req = 1'b1; cpu_addr = 16'd100; cpu_pixel = 3'b101;
    step();
    checks++; if (cpu_ack !== 1'b1 || fb_write_en !== 1'b1 || fb_write_addr !== 16'd100 || fb_write_pixel !== 3'd5)
      $display("FAIL single_cpu: got ack=%b en=%b addr=%0d pix=%0d want 1 1 100 5", cpu_ack, fb_write_en, fb_write_addr, fb_write_pixel); else passes++;
    step();
    checks++; if (cpu_ack !== 1'b0 || fb_write_en !== 1'b0)
      $display("FAIL single_cpu_gap: got ack=%b en=%b want 0 0", cpu_ack, fb_write_en); else passes++;
    step();
    checks++; if (cpu_ack !== 1'b1 || fb_write_en !== 1'b1 || fb_write_addr !== 16'd100)
      $display("FAIL single_cpu_repeat: got ack=%b en=%b addr=%0d want 1 1 100", cpu_ack, fb_write_en, fb_write_addr); else passes++;
    drop_reqs();
    step();
    checks++; if (cpu_ack !== 1'b0 || fb_write_en !== 1'b0)
      $display("FAIL single_cpu_idle: got ack=%b en=%b want 0 0", cpu_ack, fb_write_en); else passes++;
  endtask

  task automatic test_single_rast();
    rast_req = 1'b1; rast_addr = 16'd200; rast_pixel = 3'd3;
    step();
    checks++; if (rast_ack !== 1'b1 || cpu_ack !== 1'b0 || fb_write_en !== 1'b1 || fb_write_addr !== 16'd200 || fb_write_pixel !== 3'd3)
      $display("FAIL single_rast: got rack=%b cack=%b en=%b addr=%0d pix=%0d want 1 0 1 200 3", rast_ack, cpu_ack, fb_write_en, fb_write_addr, fb_write_pixel); else passes++;
    drop_reqs();
    step();
  endtask

  task automatic test_back_to_back();
    logic [A_WIDTH-1:0] exp_addr [6];
    logic [D_WIDTH-1:0] exp_pix  [6];
    logic               exp_cpu  [6];
    int ci, ri;
    exp_addr = '{16'd0, 16'd50, 16'd1, 16'd51, 16'd2, 16'd52};
    exp_pix  = '{3'd1, 3'd4, 3'd2, 3'd5, 3'd3, 3'd6};
    exp_cpu  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ci = 0; ri = 0;
    cpu_req  = 1'b1; cpu_addr  = 16'd0;  cpu_pixel  = 3'd1;
    rast_req = 1'b1; rast_addr = 16'd50; rast_pixel = 3'd4;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (cpu_ack !== exp_cpu[c] || rast_ack !== !exp_cpu[c] || fb_write_en !== 1'b1 ||
                    fb_write_addr !== exp_addr[c] || fb_write_pixel !== exp_pix[c])
        $display("FAIL contention_%0d: got cack=%b rack=%b en=%b addr=%0d pix=%0d want %b %b 1 %0d %0d",
                 c, cpu_ack, rast_ack, fb_write_en, fb_write_addr, fb_write_pixel,
                 exp_cpu[c], !exp_cpu[c], exp_addr[c], exp_pix[c]); else passes++;
      // Requester side: in the ack cycle present the next item or drop req.
      if (cpu_ack === 1'b1) begin
        ci++;
        if (ci < 3) begin cpu_addr = 16'(ci); cpu_pixel = 3'(ci + 1); end
        else cpu_req = 1'b0;
      end
      if (rast_ack === 1'b1) begin
        ri++;
        if (ri < 3) begin rast_addr = 16'(50 + ri); rast_pixel = 3'(4 + ri); end
        else rast_req = 1'b0;
      end
    end
    drop_reqs();
    step();
    checks++; if (cpu_ack !== 1'b0 || rast_ack !== 1'b0 || fb_write_en !== 1'b0)
      $display("FAIL contention_end: got cack=%b rack=%b en=%b want 0 0 0", cpu_ack, rast_ack, fb_write_en); else passes++;
  endtask

  task automatic test_out_of_range();
    cpu_req = 1'b1; cpu_addr = 16'd34239; cpu_pixel = 3'd7;
    step();
    checks++; if (cpu_ack !== 1'b1 || fb_write_en !== 1'b1 || fb_write_addr !== 16'd34239)
      $display("FAIL range_last_valid: got ack=%b en=%b addr=%0d want 1 1 34239", cpu_ack, fb_write_en, fb_write_addr); else passes++;
    cpu_addr = 16'd34240;
    step(2);
    checks++; if (cpu_ack !== 1'b1 || fb_write_en !== 1'b0)
      $display("FAIL range_first_invalid: got ack=%b en=%b want 1 0", cpu_ack, fb_write_en); else passes++;
    drop_reqs();
    step();
  endtask

  task automatic test_clear();
    int bad, bad_idx;
    logic [A_WIDTH-1:0] bad_addr;
    bad = 0; bad_idx = 0; bad_addr = '0;
    clear_req = 1'b1; clear_color = 3'b010;
    rast_req  = 1'b1; rast_addr = 16'd300; rast_pixel = 3'd1;
    step();
    clear_req = 1'b0; clear_color = 3'b101;  // must not affect the latched colour
    checks++; if (clear_busy !== 1'b1 || fb_write_en !== 1'b1 || fb_write_addr !== 16'd0 || fb_write_pixel !== 3'd2 || rast_ack !== 1'b0)
      $display("FAIL clear_start: got busy=%b en=%b addr=%0d pix=%0d rack=%b want 1 1 0 2 0", clear_busy, fb_write_en, fb_write_addr, fb_write_pixel, rast_ack); else passes++;
    for (int a = 1; a < FB_PIXELS; a++) begin
      step();
      if (clear_busy !== 1'b1 || fb_write_en !== 1'b1 || fb_write_addr !== 16'(a) ||
          fb_write_pixel !== 3'd2 || rast_ack !== 1'b0 || cpu_ack !== 1'b0) begin
        if (bad == 0) begin bad_idx = a; bad_addr = fb_write_addr; end
        bad++;
      end
    end
    checks++; if (bad != 0)
      $display("FAIL clear_sequence: %0d bad cycles, first at a=%0d got addr=%0d want 0 bad cycles", bad, bad_idx, bad_addr); else passes++;
    step();
    checks++; if (clear_busy !== 1'b0 || rast_ack !== 1'b1 || fb_write_en !== 1'b1 || fb_write_addr !== 16'd300 || fb_write_pixel !== 3'd1)
      $display("FAIL clear_release: got busy=%b rack=%b en=%b addr=%0d pix=%0d want 0 1 1 300 1", clear_busy, rast_ack, fb_write_en, fb_write_addr, fb_write_pixel); else passes++;
    drop_reqs();
    step();
  endtask

  task automatic test_reset_mid_clear();
    clear_req = 1'b1; clear_color = 3'd6;
    step();
    clear_req = 1'b0;
    step(1000);
    checks++; if (fb_write_addr !== 16'd1000 || clear_busy !== 1'b1)
      $display("FAIL midclear_progress: got addr=%0d busy=%b want 1000 1", fb_write_addr, clear_busy); else passes++;
    n_rst_async = 1'b0;
    #1;
    checks++; if (clear_busy !== 1'b0 || fb_write_en !== 1'b0 || fb_write_addr !== 16'd0)
      $display("FAIL midclear_abort: got busy=%b en=%b addr=%0d want 0 0 0", clear_busy, fb_write_en, fb_write_addr); else passes++;
    step(2);
    n_rst_async = 1'b1;
    step(3);
    checks++; if (clear_busy !== 1'b0 || fb_write_en !== 1'b0)
      $display("FAIL midclear_no_resume: got busy=%b en=%b want 0 0", clear_busy, fb_write_en); else passes++;
    clear_req = 1'b1; clear_color = 3'd4;
    step();
    clear_req = 1'b0;
    checks++; if (clear_busy !== 1'b1 || fb_write_en !== 1'b1 || fb_write_addr !== 16'd0 || fb_write_pixel !== 3'd4)
      $display("FAIL midclear_restart: got busy=%b en=%b addr=%0d pix=%0d want 1 1 0 4", clear_busy, fb_write_en, fb_write_addr, fb_write_pixel); else passes++;
    step();
    checks++; if (fb_write_addr !== 16'd1 || fb_write_pixel !== 3'd4)
      $display("FAIL midclear_restart_next: got addr=%0d pix=%0d want 1 4", fb_write_addr, fb_write_pixel); else passes++;
    n_rst_async = 1'b0;
    step();
    n_rst_async = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_cpu();
    test_single_rast();
    test_back_to_back();
    test_out_of_range();
    test_clear();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
